// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: the fetch packet carried through the instruction buffer,
// the boot PC, and a helper that turns a dual-issue strobe pair into a slot count.
package cpu_defs_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] inst;
   } inst_pkt_t;

   localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

   // Slot 2 only counts when slot 1 is also set; a lone slot-2 strobe is ignored.
   function automatic logic [1:0] slot_count(input logic en1, input logic en2);
      return {en1 & en2, en1 & ~en2};
   endfunction

endpackage

// File: rtl/inst_fifo_if.sv
// Fetch/decode side handshake of the dual-issue instruction buffer.
// master = fetch + decode (drives pushes/pops), slave = the buffer itself.
interface inst_fifo_if #(
   parameter int DW = 32
);
   logic          flush;
   logic          write_en1;
   logic          write_en2;
   logic [DW-1:0] write_addr1;
   logic [DW-1:0] write_addr2;
   logic [DW-1:0] write_data1;
   logic [DW-1:0] write_data2;
   logic          read_en1;
   logic          read_en2;
   logic          read_valid1;
   logic          read_valid2;
   logic [DW-1:0] read_addr1;
   logic [DW-1:0] read_addr2;
   logic [DW-1:0] read_data1;
   logic [DW-1:0] read_data2;
   logic          fifo_full;

   modport master (
      output flush, write_en1, write_en2, write_addr1, write_addr2,
             write_data1, write_data2, read_en1, read_en2,
      input  read_valid1, read_valid2, read_addr1, read_addr2,
             read_data1, read_data2, fifo_full
   );

   modport slave (
      input  flush, write_en1, write_en2, write_addr1, write_addr2,
             write_data1, write_data2, read_en1, read_en2,
      output read_valid1, read_valid2, read_addr1, read_addr2,
             read_data1, read_data2, fifo_full
   );
endinterface

// File: rtl/inst_fifo_mem.sv
// DEPTH-entry packet storage: two write ports at wa/wa+1 and two async read ports
// at ra/ra+1, indices wrapping mod DEPTH. Contents are not reset.
module inst_fifo_mem
   import cpu_defs_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we1,
   input  logic                     we2,
   input  logic [$clog2(DEPTH)-1:0] wa,
   input  inst_pkt_t                wd1,
   input  inst_pkt_t                wd2,
   input  logic [$clog2(DEPTH)-1:0] ra,
   output inst_pkt_t                rd1,
   output inst_pkt_t                rd2
);
   localparam int AW = $clog2(DEPTH);

   inst_pkt_t         mem [DEPTH];
   logic     [AW-1:0] wa_nxt;
   logic     [AW-1:0] ra_nxt;

   assign wa_nxt = wa + AW'(1);
   assign ra_nxt = ra + AW'(1);

   always_ff @(posedge clk) begin
      if (we1) mem[wa]     <= wd1;
      if (we2) mem[wa_nxt] <= wd2;
   end

   assign rd1 = mem[ra];
   assign rd2 = mem[ra_nxt];

endmodule

// File: rtl/inst_fifo.sv
// Dual-issue instruction buffer between fetch and decode: up to two pushes and two
// show-ahead pops per cycle, cleared by flush, fifo_full holds the PC generator.
module inst_fifo
   import cpu_defs_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int DW    = 32
) (
   input  logic         clk,
   input  logic         rst,
   inst_fifo_if.slave   fb
);
   localparam int             AW      = $clog2(DEPTH);
   localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   free;
   logic [1:0]    push_req;
   logic [1:0]    pop_req;
   logic [1:0]    push_n;
   logic [1:0]    pop_n;
   logic          push_ok;
   logic          valid1;
   logic          valid2;
   inst_pkt_t     wd1;
   inst_pkt_t     wd2;
   inst_pkt_t     rd1;
   inst_pkt_t     rd2;

   assign free     = DEPTH_C - count;
   assign push_req = slot_count(fb.write_en1, fb.write_en2);
   assign pop_req  = slot_count(fb.read_en1, fb.read_en2);

   // Space is judged on the registered count only; a same-cycle pop never makes room.
   assign push_ok  = (AW+1)'(push_req) <= free;
   assign push_n   = push_ok ? push_req : 2'd0;
   assign pop_n    = ((AW+1)'(pop_req) > count) ? count[1:0] : pop_req;

   assign wd1 = '{addr: fb.write_addr1, inst: fb.write_data1};
   assign wd2 = '{addr: fb.write_addr2, inst: fb.write_data2};

   inst_fifo_mem #(.DEPTH(DEPTH)) u_mem (
      .clk (clk),
      .we1 (push_n != 2'd0 && !fb.flush && !rst),
      .we2 (push_n == 2'd2 && !fb.flush && !rst),
      .wa  (wr_ptr),
      .wd1 (wd1),
      .wd2 (wd2),
      .ra  (rd_ptr),
      .rd1 (rd1),
      .rd2 (rd2)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (fb.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push_n);
         rd_ptr <= rd_ptr + AW'(pop_n);
         count  <= count + (AW+1)'(push_n) - (AW+1)'(pop_n);
      end
   end

   // Invalid slots read as zero so decode never sees stale storage.
   assign valid1         = count != '0;
   assign valid2         = count > (AW+1)'(1);
   assign fb.read_valid1 = valid1;
   assign fb.read_valid2 = valid2;
   assign fb.read_addr1  = valid1 ? rd1.addr[DW-1:0] : '0;
   assign fb.read_data1  = valid1 ? rd1.inst[DW-1:0] : '0;
   assign fb.read_addr2  = valid2 ? rd2.addr[DW-1:0] : '0;
   assign fb.read_data2  = valid2 ? rd2.inst[DW-1:0] : '0;
   assign fb.fifo_full   = free < (AW+1)'(2);

   a_count_bound: assert property (@(posedge clk) disable iff (rst)
      count <= DEPTH_C);
   a_no_push_full: assert property (@(posedge clk) disable iff (rst || fb.flush)
      (push_n != 2'd0) |-> !fb.fifo_full);
   a_wr2_legal: assert property (@(posedge clk) disable iff (rst)
      fb.write_en2 |-> fb.write_en1);
   a_rd2_legal: assert property (@(posedge clk) disable iff (rst)
      fb.read_en2 |-> fb.read_en1);

endmodule

// File: tb/tb_inst_fifo.sv
// Directed bench for inst_fifo: reset, fill/full, partial pops, wrap-around streaming,
// flush with concurrent traffic, and mid-stream reset.
module tb_inst_fifo;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   logic [31:0] exp_pc;
   logic [31:0] nxt_pc;

   inst_fifo_if #(.DW(32)) fb ();

   inst_fifo #(.DEPTH(16), .DW(32)) dut (
      .clk (clk),
      .rst (rst),
      .fb  (fb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      fb.flush     = 1'b0;
      fb.write_en1 = 1'b0;
      fb.write_en2 = 1'b0;
      fb.read_en1  = 1'b0;
      fb.read_en2  = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push2(input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2);
      fb.write_en1   = 1'b1;
      fb.write_en2   = 1'b1;
      fb.write_addr1 = pc;
      fb.write_addr2 = pc + 32'd4;
      fb.write_data1 = d1;
      fb.write_data2 = d2;
   endtask

   task automatic push1(input logic [31:0] pc, input logic [31:0] d1);
      fb.write_en1   = 1'b1;
      fb.write_en2   = 1'b0;
      fb.write_addr1 = pc;
      fb.write_data1 = d1;
   endtask

   initial begin
      idle();
      fb.write_addr1 = '0;
      fb.write_addr2 = '0;
      fb.write_data1 = '0;
      fb.write_data2 = '0;

      // reset
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rst_valid1", 32'(fb.read_valid1), 32'd0);
      chk("rst_valid2", 32'(fb.read_valid2), 32'd0);
      chk("rst_full",   32'(fb.fifo_full),   32'd0);
      chk("rst_addr1",  fb.read_addr1,       32'd0);
      chk("rst_data1",  fb.read_data1,       32'd0);
      chk("rst_count",  32'(dut.count),      32'd0);

      // test 1: first pair
      push2(32'hbfc0_0000, 32'h11, 32'h22);
      cyc();
      idle();
      chk("t1_valid1", 32'(fb.read_valid1), 32'd1);
      chk("t1_valid2", 32'(fb.read_valid2), 32'd1);
      chk("t1_addr1",  fb.read_addr1,       32'hbfc0_0000);
      chk("t1_addr2",  fb.read_addr2,       32'hbfc0_0004);
      chk("t1_data1",  fb.read_data1,       32'h11);
      chk("t1_data2",  fb.read_data2,       32'h22);
      chk("t1_count",  32'(dut.count),      32'd2);

      // test 2: fill to 16, then an over-capacity push is dropped
      for (int i = 1; i < 8; i++) begin
         push2(32'hbfc0_0000 + 32'(8 * i), 32'(2 * i), 32'(2 * i + 1));
         cyc();
         idle();
         chk("t2_count", 32'(dut.count), 32'(2 * i + 2));
         chk("t2_full",  32'(fb.fifo_full), (i == 7) ? 32'd1 : 32'd0);
      end
      push2(32'hdead_0000, 32'hdead, 32'hbeef);
      cyc();
      idle();
      chk("t2_drop_count", 32'(dut.count),  32'd16);
      chk("t2_drop_head",  fb.read_addr1,   32'hbfc0_0000);
      chk("t2_drop_full",  32'(fb.fifo_full), 32'd1);

      for (int k = 0; k < 7; k++) begin
         chk("t2_pop_addr1", fb.read_addr1, 32'hbfc0_0000 + 32'(8 * k));
         chk("t2_pop_addr2", fb.read_addr2, 32'hbfc0_0004 + 32'(8 * k));
         fb.read_en1 = 1'b1;
         fb.read_en2 = 1'b1;
         cyc();
         idle();
         if (k == 0) chk("t2_full_drop", 32'(fb.fifo_full), 32'd0);
      end
      chk("t2_tail_count", 32'(dut.count), 32'd2);
      fb.read_en1 = 1'b1;
      cyc();
      idle();
      chk("t2_last_head",  fb.read_addr1,  32'hbfc0_003c);
      chk("t2_last_v2",    32'(fb.read_valid2), 32'd0);

      // test 3: pop 2 requested with 1 present, then pop while empty
      fb.read_en1 = 1'b1;
      fb.read_en2 = 1'b1;
      cyc();
      idle();
      chk("t3_count",  32'(dut.count),      32'd0);
      chk("t3_valid1", 32'(fb.read_valid1), 32'd0);
      chk("t3_addr1",  fb.read_addr1,       32'd0);
      fb.read_en1 = 1'b1;
      cyc();
      idle();
      chk("t3_empty_count", 32'(dut.count),      32'd0);
      chk("t3_empty_valid", 32'(fb.read_valid1), 32'd0);

      // test 4: fill to 15, then stream 2-in/2-out across the wrap
      nxt_pc = 32'h0000_1000;
      exp_pc = 32'h0000_1000;
      for (int i = 0; i < 7; i++) begin
         push2(nxt_pc, ~nxt_pc, ~(nxt_pc + 32'd4));
         nxt_pc += 32'd8;
         cyc();
      end
      push1(nxt_pc, ~nxt_pc);
      nxt_pc += 32'd4;
      cyc();
      idle();
      chk("t4_fill_count", 32'(dut.count), 32'd15);

      for (int i = 0; i < 20; i++) begin
         chk("t4_addr1", fb.read_addr1, exp_pc);
         chk("t4_addr2", fb.read_addr2, exp_pc + 32'd4);
         chk("t4_data1", fb.read_data1, ~exp_pc);
         chk("t4_full",  32'(fb.fifo_full), (i == 0) ? 32'd1 : 32'd0);
         fb.read_en1 = 1'b1;
         fb.read_en2 = 1'b1;
         if (!fb.fifo_full) begin
            push2(nxt_pc, ~nxt_pc, ~(nxt_pc + 32'd4));
            nxt_pc += 32'd8;
         end else begin
            fb.write_en1 = 1'b0;
            fb.write_en2 = 1'b0;
         end
         cyc();
         exp_pc += 32'd8;
      end
      idle();
      chk("t4_steady_count", 32'(dut.count), 32'd13);

      chk("t4_single_addr", fb.read_addr1, exp_pc);
      fb.read_en1 = 1'b1;
      cyc();
      idle();
      exp_pc += 32'd4;
      chk("t4_single_count", 32'(dut.count), 32'd12);
      for (int k = 0; k < 6; k++) begin
         chk("t4_drain_addr1", fb.read_addr1, exp_pc);
         chk("t4_drain_addr2", fb.read_addr2, exp_pc + 32'd4);
         chk("t4_drain_data2", fb.read_data2, ~(exp_pc + 32'd4));
         fb.read_en1 = 1'b1;
         fb.read_en2 = 1'b1;
         cyc();
         idle();
         exp_pc += 32'd8;
      end
      chk("t4_drain_count", 32'(dut.count), 32'd0);

      // test 5: flush wins over concurrent push and pop
      for (int i = 0; i < 3; i++) begin
         push2(32'h0000_3000 + 32'(8 * i), 32'h5a, 32'ha5);
         cyc();
      end
      idle();
      chk("t5_count6", 32'(dut.count), 32'd6);
      push2(32'h0000_4000, 32'h1, 32'h2);
      fb.read_en1 = 1'b1;
      fb.flush    = 1'b1;
      cyc();
      idle();
      chk("t5_count",  32'(dut.count),      32'd0);
      chk("t5_valid1", 32'(fb.read_valid1), 32'd0);
      chk("t5_full",   32'(fb.fifo_full),   32'd0);
      chk("t5_addr1",  fb.read_addr1,       32'd0);
      push1(32'h8000_0180, 32'h0000_0180);
      cyc();
      idle();
      chk("t5_redir_v1",   32'(fb.read_valid1), 32'd1);
      chk("t5_redir_addr", fb.read_addr1,       32'h8000_0180);
      chk("t5_redir_v2",   32'(fb.read_valid2), 32'd0);

      // test 6: reset mid-stream with 9 entries
      for (int i = 0; i < 4; i++) begin
         push2(32'h0000_5000 + 32'(8 * i), 32'h77, 32'h88);
         cyc();
      end
      idle();
      chk("t6_count9", 32'(dut.count),    32'd9);
      chk("t6_full0",  32'(fb.fifo_full), 32'd0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("t6_valid1", 32'(fb.read_valid1), 32'd0);
      chk("t6_valid2", 32'(fb.read_valid2), 32'd0);
      chk("t6_addr1",  fb.read_addr1,       32'd0);
      chk("t6_data1",  fb.read_data1,       32'd0);
      chk("t6_full",   32'(fb.fifo_full),   32'd0);
      push1(32'h0000_2000, 32'h0000_0abc);
      cyc();
      idle();
      chk("t6_new_head", fb.read_addr1, 32'h0000_2000);
      chk("t6_new_data", fb.read_data1, 32'h0000_0abc);
      chk("t6_new_v2",   32'(fb.read_valid2), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
